// File: rtl/gray_pkg.sv
// Shared width default and reference helpers for the Gray-to-binary converter.
// The helpers take a zero-extended vector of up to MAX_WIDTH bits.
package gray_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int MAX_WIDTH = 32;

  function automatic int unsigned popcount(input logic [MAX_WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  // Running XOR from the MSB down; zero upper bits leave the result unchanged.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    logic                 acc;
    b   = '0;
    acc = 1'b0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_df_if.sv
// Gray-in / binary-out bundle between a Gray-coded source and the converter.
// master = source side (drives the Gray word), slave = converter side.
interface gray2bin_df_if
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] g_in;
  logic             g_valid;
  logic [WIDTH-1:0] b_comb;
  logic [WIDTH-1:0] b_out;
  logic             b_valid;
  logic             step_err;

  modport master (
    output g_in, g_valid,
    input  b_comb, b_out, b_valid, step_err
  );

  modport slave (
    input  g_in, g_valid,
    output b_comb, b_out, b_valid, step_err
  );

endinterface

// File: rtl/gray2bin_core.sv
// Purely combinational Gray-to-binary core: each binary bit is the XOR of
// all Gray bits from the MSB down to that position.
module gray2bin_core
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  // Per-bit reduction keeps the chain free of self-referencing vector nets.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i] = ^g[WIDTH-1:i];
  end

endmodule

// File: rtl/gray2bin_df.sv
// Gray-to-binary converter: zero-latency b_comb plus a registered, valid-qualified b_out.
// Define GRAY2BIN_STEPCHK_EN to flag non-adjacent consecutive valid codes on step_err.
module gray2bin_df
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  gray2bin_df_if.slave     bus
);

  logic [WIDTH-1:0] b_conv;
  logic [WIDTH-1:0] b_out_q;
  logic             b_valid_q;

  gray2bin_core #(.WIDTH(WIDTH)) u_core (
    .g (bus.g_in),
    .b (b_conv)
  );

  assign bus.b_comb  = b_conv;
  assign bus.b_out   = b_out_q;
  assign bus.b_valid = b_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_out_q   <= '0;
      b_valid_q <= 1'b0;
    end else begin
      b_valid_q <= bus.g_valid;
      if (bus.g_valid) begin
        b_out_q <= b_conv;
      end
    end
  end

`ifdef GRAY2BIN_STEPCHK_EN
  logic [WIDTH-1:0] prev_q;
  logic             have_prev_q;
  logic             step_err_q;
  logic             multi_bit;

  // A repeated code (distance 0) is legal; only jumps of two or more bits flag.
  assign multi_bit = popcount(MAX_WIDTH'(bus.g_in ^ prev_q)) > 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      step_err_q  <= 1'b0;
    end else if (bus.g_valid) begin
      prev_q      <= bus.g_in;
      have_prev_q <= 1'b1;
      step_err_q  <= have_prev_q & multi_bit;
    end else begin
      step_err_q  <= 1'b0;
    end
  end

  assign bus.step_err = step_err_q;
`else
  assign bus.step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray2bin_df.sv
// Self-checking bench for gray2bin_df (WIDTH=4); expectations of step_err follow
// whether GRAY2BIN_STEPCHK_EN is defined for the build.
module tb_gray2bin_df;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  // model state
  logic [W-1:0] m_bout;
  logic         m_bvalid;
  logic         m_step;
  logic [W-1:0] m_prev;
  logic         m_have;

  localparam logic [W-1:0] SWEEP [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0111, 4'b0110, 4'b0100, 4'b0101,
    4'b1111, 4'b1110, 4'b1100, 4'b1101, 4'b1000, 4'b1001, 4'b1011, 4'b1010
  };

  localparam logic [W-1:0] STEP_SEQ [8] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0011, 4'b0010, 4'b1010, 4'b1000, 4'b0000
  };

`ifdef GRAY2BIN_STEPCHK_EN
  localparam bit STEPCHK = 1'b1;
`else
  localparam bit STEPCHK = 1'b0;
`endif

  gray2bin_df_if #(.WIDTH(W)) bus ();

  gray2bin_df #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Binary value = position of the code in the reflected Gray sequence.
  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    for (int n = 0; n < (1 << W); n++) begin
      logic [W-1:0] nv;
      nv = W'(n);
      if ((nv ^ (nv >> 1)) == g) return nv;
    end
    return '0;
  endfunction

  function automatic int hamming(input logic [W-1:0] a, input logic [W-1:0] b);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) if (a[i] != b[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_bout   = '0;
    m_bvalid = 1'b0;
    m_step   = 1'b0;
    m_prev   = '0;
    m_have   = 1'b0;
  endtask

  // Apply inputs, advance one edge, update model, sample #1 later.
  task automatic step_clk(input logic v, input logic [W-1:0] g);
    bus.g_valid = v;
    bus.g_in    = g;
    @(posedge clk);
    if (v) begin
      m_bout   = ref_bin(g);
      m_bvalid = 1'b1;
      m_step   = STEPCHK && m_have && (hamming(g, m_prev) > 1);
      m_prev   = g;
      m_have   = 1'b1;
    end else begin
      m_bvalid = 1'b0;
      m_step   = 1'b0;
    end
    #1;
  endtask

  task automatic check_regs(input string tag);
    checks++;
    if (bus.b_out !== m_bout || bus.b_valid !== m_bvalid || bus.step_err !== m_step) begin
      errors++;
      $display("FAIL %s: got b_out=%b b_valid=%b step_err=%b, expected b_out=%b b_valid=%b step_err=%b",
               tag, bus.b_out, bus.b_valid, bus.step_err, m_bout, m_bvalid, m_step);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.g_valid = 1'b0;
    bus.g_in    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bus.g_valid = 1'b0;
      bus.g_in    = W'(i);
      #1;
      checks++;
      if (bus.b_comb !== SWEEP[i] || bus.b_comb !== ref_bin(W'(i))) begin
        errors++;
        $display("FAIL sweep g=%b: got b_comb=%b expected %b", W'(i), bus.b_comb, SWEEP[i]);
      end
    end
  endtask

  task automatic test_spot();
    logic [W-1:0] gs [4];
    logic [W-1:0] bs [4];
    gs = '{4'b0110, 4'b1000, 4'b1111, 4'b0011};
    bs = '{4'b0100, 4'b1111, 4'b1010, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      bus.g_in = gs[i];
      #1;
      checks++;
      if (bus.b_comb !== bs[i]) begin
        errors++;
        $display("FAIL spot g=%b: got b_comb=%b expected %b", gs[i], bus.b_comb, bs[i]);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    step_clk(1'b1, 4'b1000);
    checks++;
    if (bus.b_out !== 4'b1111 || bus.b_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_n: got b_out=%b b_valid=%b expected 1111/1", bus.b_out, bus.b_valid);
    end
    step_clk(1'b0, 4'b0101);
    checks++;
    if (bus.b_out !== 4'b1111 || bus.b_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_hold: got b_out=%b b_valid=%b expected 1111/0", bus.b_out, bus.b_valid);
    end
    check_regs("latency_model");
  endtask

  task automatic test_async_reset();
    do_reset();
    step_clk(1'b1, 4'b0110);
    step_clk(1'b1, 4'b0111);
    step_clk(1'b1, 4'b1101);
    check_regs("pre_async");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_regs("async_reset");
    checks++;
    if (bus.b_comb !== ref_bin(4'b1101)) begin
      errors++;
      $display("FAIL async_bcomb: got b_comb=%b expected %b", bus.b_comb, ref_bin(4'b1101));
    end
    // rst wins over a simultaneous g_valid
    step_clk(1'b1, 4'b1010);
    m_bout = '0; m_bvalid = 1'b0; m_step = 1'b0; m_have = 1'b0; m_prev = '0;
    check_regs("rst_wins");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stepchk();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step_clk(1'b1, STEP_SEQ[i]);
      check_regs($sformatf("step_seq%0d", i));
    end
    step_clk(1'b1, 4'b0011);
    checks++;
    if (bus.step_err !== STEPCHK) begin
      errors++;
      $display("FAIL step_jump: got step_err=%b expected %b", bus.step_err, STEPCHK);
    end
    step_clk(1'b0, 4'b1111);
    check_regs("step_idle_clear");
    step_clk(1'b1, 4'b0001);
    check_regs("step_after_idle");
    do_reset();
    step_clk(1'b1, 4'b0110);
    check_regs("step_first_after_reset");
    step_clk(1'b1, 4'b0110);
    check_regs("step_repeat");
  endtask

  task automatic test_random();
    logic [W-1:0] g;
    logic         v;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) g = m_prev ^ W'(1 << $urandom_range(0, W - 1));
      else                           g = W'($urandom);
      step_clk(v, g);
      check_regs($sformatf("random%0d", i));
      checks++;
      if (bus.b_comb !== ref_bin(g)) begin
        errors++;
        $display("FAIL random_bcomb%0d: got %b expected %b", i, bus.b_comb, ref_bin(g));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step_clk(1'b1, W'(i) ^ (W'(i) >> 1));
      checks++;
      if (bus.b_out !== W'(i) || bus.b_valid !== 1'b1 || bus.step_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d: got b_out=%b b_valid=%b step_err=%b expected %b/1/0",
                 i, bus.b_out, bus.b_valid, bus.step_err, W'(i));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sweep();
    test_spot();
    test_latency();
    test_async_reset();
    test_stepchk();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
